// File: rtl/tone_seq.sv
// Programmable NOTES-entry square-wave note sequencer with a run-time writable table.
// Build option: define TONE_SEQ_GAP_EN to silence the last GAP cycles of every note.
module tone_seq #(
    parameter int NOTES = 8,
    parameter int DIVW  = 16,
    parameter int DURW  = 24,
    parameter int GAP   = 4,
    localparam int AW   = $clog2(NOTES)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            button,
    input  logic            loop,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [DIVW-1:0] wr_div,
    input  logic [DURW-1:0] wr_dur,
    output logic            ch_out,
    output logic            playing,
    output logic [AW-1:0]   note_idx,
    output logic            done
);

    localparam logic [AW-1:0] LAST = AW'(NOTES - 1);
`ifdef TONE_SEQ_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    typedef enum logic {IDLE, PLAY} state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync2_q, sync3_q;
    logic            btn_edge;
    logic [DIVW-1:0] div_tab [NOTES];
    logic [DURW-1:0] dur_tab [NOTES];
    logic [DIVW-1:0] act_div_q, ld_div;
    logic [DURW-1:0] act_dur_q, ld_dur;
    logic [DIVW-1:0] tone_cnt_q;
    logic [DURW-1:0] dur_cnt_q, eff_dur;
    logic            ch_q, done_q, playing_q;
    logic [AW-1:0]   idx_q, load_idx;
    logic            term, start, stop, advance, finish, gap_zone;

    assign btn_edge = sync2_q & ~sync3_q;
    assign eff_dur  = (act_dur_q == '0) ? DURW'(1) : act_dur_q;
    assign term     = (dur_cnt_q == eff_dur - DURW'(1));

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        stop    = 1'b0;
        advance = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_edge) begin
                    state_d = PLAY;
                    start   = 1'b1;
                end
            end
            PLAY: begin
                // A stop edge takes priority over the end of the last note.
                if (btn_edge) begin
                    state_d = IDLE;
                    stop    = 1'b1;
                end else if (term) begin
                    if (idx_q == LAST && !loop) begin
                        state_d = IDLE;
                        finish  = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Entry being loaded sees a same-cycle table write (write-first).
    always_comb begin
        load_idx = (start || idx_q == LAST) ? '0 : idx_q + 1'b1;
        if (wr_en && wr_addr == load_idx) begin
            ld_div = wr_div;
            ld_dur = wr_dur;
        end else begin
            ld_div = div_tab[load_idx];
            ld_dur = dur_tab[load_idx];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sync3_q    <= 1'b0;
            act_div_q  <= '0;
            act_dur_q  <= '0;
            tone_cnt_q <= '0;
            dur_cnt_q  <= '0;
            ch_q       <= 1'b0;
            idx_q      <= '0;
            done_q     <= 1'b0;
            playing_q  <= 1'b0;
            for (int i = 0; i < NOTES; i++) begin
                div_tab[i] <= '0;
                dur_tab[i] <= '0;
            end
        end else begin
            sync1_q   <= button;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
            state_q   <= state_d;
            playing_q <= (state_d == PLAY);
            done_q    <= finish;
            if (wr_en && (int'(wr_addr) < NOTES)) begin
                div_tab[wr_addr] <= wr_div;
                dur_tab[wr_addr] <= wr_dur;
            end
            if (start || advance) begin
                act_div_q  <= ld_div;
                act_dur_q  <= ld_dur;
                tone_cnt_q <= '0;
                dur_cnt_q  <= '0;
                ch_q       <= 1'b0;
                idx_q      <= load_idx;
            end else if (stop || finish) begin
                tone_cnt_q <= '0;
                dur_cnt_q  <= '0;
                ch_q       <= 1'b0;
                idx_q      <= '0;
            end else if (state_q == PLAY) begin
                dur_cnt_q <= dur_cnt_q + DURW'(1);
                if (act_div_q == '0) begin
                    tone_cnt_q <= '0;
                    ch_q       <= 1'b0;
                end else if (tone_cnt_q == act_div_q - DIVW'(1)) begin
                    tone_cnt_q <= '0;
                    ch_q       <= ~ch_q;
                end else begin
                    tone_cnt_q <= tone_cnt_q + DIVW'(1);
                end
            end
        end
    end

    // Articulation window: the tail of each note, or the whole note when it is short.
    assign gap_zone = (eff_dur <= DURW'(GAP)) || (dur_cnt_q >= eff_dur - DURW'(GAP));

    assign ch_out   = ch_q & ~(GAP_EN & gap_zone);
    assign playing  = playing_q;
    assign note_idx = idx_q;
    assign done     = done_q;

endmodule

// File: tb/tb_tone_seq.sv
// Bench for tone_seq: time-based reference model feeds an expected queue, a monitor
// compares every cycle's {playing, note_idx, ch_out, done} against it.
module tb_tone_seq;

    localparam int NOTES = 4;
    localparam int DIVW  = 8;
    localparam int DURW  = 8;
    localparam int GAP   = 4;
    localparam int AW    = 2;
    localparam int W     = AW + 3;

    logic            clk, rstn, button, loop, wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DIVW-1:0] wr_div;
    logic [DURW-1:0] wr_dur;
    logic            ch_out, playing, done;
    logic [AW-1:0]   note_idx;

    tone_seq #(.NOTES(NOTES), .DIVW(DIVW), .DURW(DURW), .GAP(GAP)) dut (
        .clk(clk), .rstn(rstn), .button(button), .loop(loop),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_div(wr_div), .wr_dur(wr_dur),
        .ch_out(ch_out), .playing(playing), .note_idx(note_idx), .done(done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard
    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    // reference model: note position kept as "age since the note started"
    int tdiv [NOTES];
    int tdur [NOTES];
    bit m_play;
    int m_idx, m_div, m_dur, m_age;
    bit h1, h2, h3;

    function void m_load(input int i);
        m_idx = i;
        m_div = tdiv[i];
        m_dur = (tdur[i] == 0) ? 1 : tdur[i];
        m_age = 0;
    endfunction

    task automatic model_step();
        bit e, dn, ch;
        if (!rstn) begin
            m_play = 0; m_idx = 0; m_div = 0; m_dur = 1; m_age = 0;
            h1 = 0; h2 = 0; h3 = 0;
            for (int i = 0; i < NOTES; i++) begin
                tdiv[i] = 0;
                tdur[i] = 0;
            end
            exp_q.push_back('0);
            return;
        end
        // 2-flop synchronizer plus edge detect: a rise sampled at edge j acts at edge j+2
        e  = h2 & ~h3;
        h3 = h2; h2 = h1; h1 = button;
        if (wr_en) begin
            tdiv[wr_addr] = int'(wr_div);
            tdur[wr_addr] = int'(wr_dur);
        end
        dn = 0;
        if (!m_play) begin
            if (e) begin
                m_play = 1;
                m_load(0);
            end
        end else if (e) begin
            m_play = 0;
            m_idx  = 0;
        end else if (m_age == m_dur - 1) begin
            if (m_idx == NOTES - 1 && !loop) begin
                m_play = 0;
                m_idx  = 0;
                dn     = 1;
            end else begin
                m_load((m_idx + 1) % NOTES);
            end
        end else begin
            m_age++;
        end
        ch = m_play && (m_div != 0) && (((m_age / m_div) % 2) == 1);
`ifdef TONE_SEQ_GAP_EN
        if (m_play && m_age >= m_dur - GAP) ch = 0;
`endif
        exp_q.push_back({m_play, AW'(m_idx), ch, dn});
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // monitor
    initial forever begin
        logic [W-1:0] exp_v, act_v;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {playing, note_idx, ch_out, done};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL cycle_check t=%0t actual play=%0b idx=%0d ch=%0b done=%0b required play=%0b idx=%0d ch=%0b done=%0b",
                         $time, act_v[W-1], act_v[W-2:2], act_v[1], act_v[0],
                         exp_v[W-1], exp_v[W-2:2], exp_v[1], exp_v[0]);
            end
        end
    end

    // driver tasks: inputs change 1 time unit after the falling edge
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wr(input int a, input int d, input int u);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_div  = DIVW'(d);
        wr_dur  = DURW'(u);
        tick(1);
        wr_en   = 1'b0;
    endtask

    task automatic press(input int hold);
        button = 1'b1;
        tick(hold);
        button = 1'b0;
        tick(1);
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            tick(1);
            if (done) seen = 1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s actual done_seen=0 required done_seen=1 within %0d cycles", name, budget);
        end
    endtask

    initial begin
        logic [W-1:0] act_v;
        rstn = 1'b0; button = 1'b0; loop = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_div = '0; wr_dur = '0;
        tick(3);
        rstn = 1'b1;
        tick(2);

        // one-shot pass through {4,3,2,5} x 10
        wr(0, 4, 10); wr(1, 3, 10); wr(2, 2, 10); wr(3, 5, 10);
        loop = 1'b0;
        press(2);
        wait_done(80, "oneshot_done");
        tick(5);

        // looping, rewrite of the playing entry, then stop mid-note
        loop = 1'b1;
        press(1);
        tick(14);
        wr(1, 7, 10);
        tick(50);
        press(1);
        tick(5);

        // start edge coinciding with a write to entry 0
        loop = 1'b0;
        button = 1'b1; tick(1);
        button = 1'b0; tick(1);
        wr(0, 6, 3);
        tick(2);
        wait_done(80, "write_first_done");
        tick(3);

        // silent one-cycle entry
        wr(1, 0, 0);
        press(1);
        wait_done(80, "zero_entry_done");
        tick(3);

        // asynchronous reset while playing
        loop = 1'b1;
        press(1);
        tick(7);
        rstn = 1'b0;
        #1;
        act_v = {playing, note_idx, ch_out, done};
        total++;
        if (act_v !== '0) begin
            bad++;
            $display("FAIL async_reset actual outputs=%b required outputs=%b", act_v, {W{1'b0}});
        end
        tick(2);
        rstn = 1'b1;
        tick(2);

        // cleared table plays as four one-cycle rests
        loop = 1'b0;
        press(1);
        wait_done(30, "cleared_table_done");
        tick(3);

        // articulation-gap pattern (plain tone when the gap is disabled)
        for (int i = 0; i < NOTES; i++) wr(i, 1, 10);
        press(1);
        wait_done(80, "gap_table_done");
        tick(3);

        // randomized writes, button activity and loop changes
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) loop = 1'($urandom_range(0, 1));
            if (r < 4) begin
                wr($urandom_range(0, NOTES - 1), $urandom_range(0, 6), $urandom_range(0, 12));
            end else if (r < 6) begin
                button = ~button;
                tick(1);
            end else begin
                tick($urandom_range(1, 6));
            end
        end
        button = 1'b0;
        tick(4);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain actual pending=%0d required pending=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual time=%0t required finish before limit", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
